// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x32 register file and its write-port sequencer.
// Holds geometry constants, the sequencer state encoding and the round-robin pointer helper.
package regfile_pkg;

    localparam int REG_AW     = 5;
    localparam int REG_DW     = 32;
    localparam int NUM_REGS   = 32;
    localparam int CLEAR_LAST = 31;

    // Requester index width, sized for the largest legal NREQ of 8.
    localparam int RR_IW = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic logic [RR_IW-1:0] rr_next(input logic [RR_IW-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + RR_IW'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
// Grant depends only on req and ptr, never on the consumer's acceptance.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [RR_IW-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [RR_IW-1:0] gnt_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = RR_IW'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sequencer for the register file write port: zero-fills r1..r31 after reset or on request,
// then grants one writeback source per cycle round-robin and drives registered write outputs.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 f_regwrite,
    output logic [AW-1:0]        writereg,
    output logic [DW-1:0]        writedata,
    output logic [RR_IW-1:0]     grant_id
);

    localparam logic [AW-1:0] LAST_REG = AW'(CLEAR_LAST);
    localparam logic [AW-1:0] FIRST_REG = AW'(1);

    state_e             r_state;
    logic [AW-1:0]      r_cnt;
    logic [RR_IW-1:0]   r_ptr;
    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_data;
    logic [RR_IW-1:0]   r_gid;

    logic [NREQ-1:0]    w_gnt;
    logic [RR_IW-1:0]   w_gnt_idx;
    logic               w_open;
    logic               w_take;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_data;

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // A clear request in RUN wins over any pending writeback that cycle.
    assign w_open    = (r_state == RUN) && !clear_start;
    assign req_ready = w_open ? w_gnt : '0;
    assign w_take    = w_open && (|req_valid);

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_addr = req_addr[i*AW +: AW];
                w_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= FIRST_REG;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_gid   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_we   <= 1'b1;
                    r_addr <= r_cnt;
                    r_data <= '0;
                    r_cnt  <= r_cnt + AW'(1);
                    if (r_cnt == LAST_REG)
                        r_state <= RUN;
                end
                RUN: begin
                    if (clear_start) begin
                        r_state <= CLEAR;
                        r_cnt   <= FIRST_REG;
                        r_we    <= 1'b0;
                    end else if (w_take) begin
                        // r0 is hardwired zero: complete the handshake but suppress the strobe.
                        r_we  <= (w_addr != '0);
                        r_gid <= w_gnt_idx;
                        r_ptr <= rr_next(w_gnt_idx, NREQ);
                        if (w_addr != '0) begin
                            r_addr <= w_addr;
                            r_data <= w_data;
                        end
                    end else begin
                        r_we <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= FIRST_REG;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = (r_state == CLEAR);
    assign f_regwrite = r_we;
    assign writereg   = r_addr;
    assign writedata  = r_data;
    assign grant_id   = r_gid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: cycle model plus a queue of expected writes.
module tb_regfile_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               clear_start;
    logic               clear_busy;
    logic               f_regwrite;
    logic [AW-1:0]      writereg;
    logic [DW-1:0]      writedata;
    logic [2:0]         grant_id;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .f_regwrite  (f_regwrite),
        .writereg    (writereg),
        .writedata   (writedata),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;

    // reference model state
    bit       m_run;
    int       m_cnt;
    int       m_ptr;
    int       m_gid;
    bit       m_we;
    int       last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_run = 0; m_cnt = 1; m_ptr = 0; m_gid = 0; m_we = 0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // One cycle: check outputs and pop the scoreboard at negedge, advance the model,
    // then return just after the next rising edge so callers can change inputs.
    task automatic tick();
        logic [NREQ-1:0] er;
        wr_t e;
        int g;
        @(negedge clk);
        chk("f_regwrite", 64'(f_regwrite), 64'(m_we));
        if (f_regwrite && sb.size() > 0) begin
            e = sb.pop_front();
            chk("writereg", 64'(writereg), 64'(e.addr));
            chk("writedata", 64'(writedata), 64'(e.data));
        end
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("clear_busy", 64'(clear_busy), 64'(!m_run));
        er = '0;
        g = -1;
        if (m_run && !clear_start) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(er));
        last_g = g;
        if (!m_run) begin
            sb.push_back('{addr: AW'(m_cnt), data: '0});
            m_we = 1;
            if (m_cnt == 31) m_run = 1;
            m_cnt++;
        end else if (clear_start) begin
            m_run = 0; m_cnt = 1; m_we = 0;
        end else if (g >= 0) begin
            m_gid = g;
            m_ptr = (g + 1) % NREQ;
            if (req_addr[g*AW +: AW] != '0) begin
                sb.push_back('{addr: req_addr[g*AW +: AW], data: req_data[g*DW +: DW]});
                m_we = 1;
            end else begin
                m_we = 0;
            end
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp[6] = '{0, 1, 2, 0, 1, 2};
        rst_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        clear_start = 1'b0;
        model_reset();
        #12;
        chk("rst_f_regwrite", 64'(f_regwrite), 64'(0));
        chk("rst_writereg", 64'(writereg), 64'(0));
        chk("rst_writedata", 64'(writedata), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_clear_busy", 64'(clear_busy), 64'(1));
        chk("rst_req_ready", 64'(req_ready), 64'(0));

        // reset clear with every requester already valid
        set_req(0, 5'd4, 32'h1111_0000);
        set_req(1, 5'd5, 32'h2222_0000);
        set_req(2, 5'd6, 32'h3333_0000);
        req_valid = 3'b111;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (31) tick();
        chk("clear_done_busy", 64'(clear_busy), 64'(0));

        // round-robin over three held requesters
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_order", 64'(last_g), 64'(rr_exp[k]));
        end
        req_valid = '0;
        tick();

        // single request from requester 1
        set_req(1, 5'd7, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1 chk("single_ready", 64'(req_ready), 64'(3'b010));
        tick();
        req_valid = '0;
        chk("single_we", 64'(f_regwrite), 64'(1));
        chk("single_addr", 64'(writereg), 64'(7));
        chk("single_data", 64'(writedata), 64'(32'hDEAD_BEEF));
        chk("single_gid", 64'(grant_id), 64'(1));
        tick();

        // write to r0 is accepted and dropped
        set_req(2, 5'd0, 32'h0000_1234);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        chk("r0_we", 64'(f_regwrite), 64'(0));
        chk("r0_gid", 64'(grant_id), 64'(2));
        set_req(0, 5'd9, 32'h0BAD_F00D);
        req_valid = 3'b011;
        #1 chk("after_r0_ready", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = '0;
        chk("after_r0_gid", 64'(grant_id), 64'(0));
        chk("after_r0_addr", 64'(writereg), 64'(9));
        tick();

        // clear_start beats a pending request
        set_req(0, 5'd12, 32'hCAFE_0001);
        req_valid = 3'b001;
        clear_start = 1'b1;
        #1 chk("cs_ready", 64'(req_ready), 64'(0));
        tick();
        clear_start = 1'b0;
        repeat (32) tick();
        req_valid = '0;
        chk("cs_post_we", 64'(f_regwrite), 64'(1));
        chk("cs_post_addr", 64'(writereg), 64'(12));
        chk("cs_post_data", 64'(writedata), 64'(32'hCAFE_0001));
        tick();

        // make grant_id non-zero so the async reset is visible on it
        set_req(2, 5'd3, 32'h0000_0033);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        tick();

        // async reset in the middle of a clear
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 40 && m_cnt != 15; k++) tick();
        chk("mid_clear_cnt", 64'(writereg), 64'(14));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 64'(f_regwrite), 64'(0));
        chk("arst_addr", 64'(writereg), 64'(0));
        chk("arst_gid", 64'(grant_id), 64'(0));
        chk("arst_busy", 64'(clear_busy), 64'(1));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("reclear_first", 64'(writereg), 64'(1));
        repeat (31) tick();
        set_req(1, 5'd5, 32'h5555_AAAA);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("sb_left", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
